udm_uart_tx: RTL and testbench

Buffered UART transmitter for the UDM debug path: the device-to-host counterpart of the host-driven `rx` line. Bytes from the UDM response logic are queued in a small FIFO and serialized onto `tx_o` as 8-bit frames. The frame has a runtime-programmable bit period, an optional even or odd parity bit, and one or two stop bits. Queued bytes are sent back-to-back with no idle gap.

---
 rtl/udm_uart_pkg.sv | 15 +
 rtl/udm_fifo.sv | 71 +++++++
 rtl/udm_uart_tx.sv | 179 +++++++++++++++++
 tb/tb_udm_uart_tx.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/udm_uart_pkg.sv
// Shared types and constants for the UDM UART blocks.
package udm_uart_pkg;

   localparam int unsigned UART_DATA_BITS     = 8;
   localparam int unsigned UART_MIN_BITPERIOD = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_tx_state_t;

endpackage

// File: rtl/udm_fifo.sv
// Synchronous FIFO with registered full/empty flags; push ignored when full, pop ignored when empty.
module udm_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             arst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             do_push, do_pop;

   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & ~empty_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

   // Pointer/count update; pointers wrap naturally since DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Control state registers.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array; contents are don't-care once the pointers reset.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/udm_uart_tx.sv
// Buffered UART transmitter: byte FIFO feeding a frame serializer with latched per-frame config.
module udm_uart_tx
   import udm_uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned BITPERIOD_W = 32
) (
   input  logic                   clk_i,
   input  logic                   arst_i,
   input  logic [BITPERIOD_W-1:0] bitperiod_i,
   input  logic                   parity_en_i,
   input  logic                   parity_odd_i,
   input  logic                   stop2_i,
   input  logic                   tx_req_i,
   input  logic [7:0]             tx_data_i,
   output logic                   tx_ack_o,
   output logic                   tx_o,
   output logic                   busy_o,
   output logic                   fifo_full_o,
   output logic                   fifo_empty_o
);

   localparam int unsigned DW = UART_DATA_BITS;

   uart_tx_state_t         state_q, state_d;
   logic [BITPERIOD_W-1:0] timer_q, timer_d;
   logic [BITPERIOD_W-1:0] period_q, period_d;
   logic [BITPERIOD_W-1:0] period_eff;
   logic [2:0]             bit_idx_q, bit_idx_d;
   logic [DW-1:0]          shift_q, shift_d;
   logic                   parity_q, parity_d;
   logic                   par_en_q, par_en_d;
   logic                   stop2_q, stop2_d;
   logic                   stop_cnt_q, stop_cnt_d;
   logic                   tx_q, tx_d;
   logic                   busy_q, busy_d;
   logic                   fifo_pop, fifo_full, fifo_empty, load, bit_end;
   logic [DW-1:0]          fifo_data;

   assign tx_ack_o     = tx_req_i & ~fifo_full;
   assign tx_o         = tx_q;
   assign busy_o       = busy_q;
   assign fifo_full_o  = fifo_full;
   assign fifo_empty_o = fifo_empty;

   // Periods below the minimum are clamped up.
   assign period_eff = (bitperiod_i < BITPERIOD_W'(UART_MIN_BITPERIOD)) ?
                       BITPERIOD_W'(UART_MIN_BITPERIOD) : bitperiod_i;
   assign bit_end    = (timer_q == '0);

   udm_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .arst_i  (arst_i),
      .push_i  (tx_ack_o),
      .data_i  (tx_data_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   // Next-state, bit timer, shifter and parity; tx_o follows the current state one cycle later.
   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      period_d   = period_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      parity_d   = parity_q;
      par_en_d   = par_en_q;
      stop2_d    = stop2_q;
      stop_cnt_d = stop_cnt_q;
      fifo_pop   = 1'b0;
      load       = 1'b0;
      tx_d       = 1'b1;

      case (state_q)
         ST_IDLE: begin
            tx_d = 1'b1;
            if (!fifo_empty) load = 1'b1;
         end
         ST_START: begin
            tx_d = 1'b0;
            if (bit_end) begin
               state_d = ST_DATA;
               timer_d = period_q - BITPERIOD_W'(1);
            end else begin
               timer_d = timer_q - BITPERIOD_W'(1);
            end
         end
         ST_DATA: begin
            tx_d = shift_q[0];
            if (bit_end) begin
               parity_d  = parity_q ^ shift_q[0];
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               timer_d   = period_q - BITPERIOD_W'(1);
               if (bit_idx_q == 3'(DW - 1)) begin
                  state_d    = par_en_q ? ST_PARITY : ST_STOP;
                  stop_cnt_d = 1'b0;
               end
            end else begin
               timer_d = timer_q - BITPERIOD_W'(1);
            end
         end
         ST_PARITY: begin
            tx_d = parity_q;
            if (bit_end) begin
               state_d = ST_STOP;
               timer_d = period_q - BITPERIOD_W'(1);
            end else begin
               timer_d = timer_q - BITPERIOD_W'(1);
            end
         end
         ST_STOP: begin
            tx_d = 1'b1;
            if (bit_end) begin
               if (stop2_q && !stop_cnt_q) begin
                  stop_cnt_d = 1'b1;
                  timer_d    = period_q - BITPERIOD_W'(1);
               end else if (!fifo_empty) begin
                  load = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               timer_d = timer_q - BITPERIOD_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Frame start: pop a byte and freeze the line config for the whole frame.
      if (load) begin
         fifo_pop   = 1'b1;
         state_d    = ST_START;
         shift_d    = fifo_data;
         period_d   = period_eff;
         timer_d    = period_eff - BITPERIOD_W'(1);
         par_en_d   = parity_en_i;
         stop2_d    = stop2_i;
         parity_d   = parity_odd_i;
         bit_idx_d  = 3'd0;
         stop_cnt_d = 1'b0;
      end

      busy_d = (state_d != ST_IDLE) | ~fifo_empty;
   end

   // State and datapath registers; reset forces the line high immediately.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         period_q   <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         parity_q   <= 1'b0;
         par_en_q   <= 1'b0;
         stop2_q    <= 1'b0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         period_q   <= period_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         parity_q   <= parity_d;
         par_en_q   <= par_en_d;
         stop2_q    <= stop2_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

endmodule

// File: tb/tb_udm_uart_tx.sv
// Testbench for udm_uart_tx: waveform-level reference model of UART frames.
module tb_udm_uart_tx;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic [31:0] bitperiod_i = 32'd4;
   logic        parity_en_i = 1'b0;
   logic        parity_odd_i = 1'b0;
   logic        stop2_i = 1'b0;
   logic        tx_req_i = 1'b0;
   logic [7:0]  tx_data_i = 8'h00;
   logic        tx_ack_o, tx_o, busy_o, fifo_full_o, fifo_empty_o;

   int n_cmp = 0;
   int n_err = 0;

   logic       exp_q[$];
   logic       cap_tx[$];
   logic       cap_busy[$];
   logic       cap_en = 1'b0;
   logic [7:0] burst_q[$];

   udm_uart_tx #(.FIFO_DEPTH(8), .BITPERIOD_W(32)) dut (
      .clk_i        (clk),
      .arst_i       (arst),
      .bitperiod_i  (bitperiod_i),
      .parity_en_i  (parity_en_i),
      .parity_odd_i (parity_odd_i),
      .stop2_i      (stop2_i),
      .tx_req_i     (tx_req_i),
      .tx_data_i    (tx_data_i),
      .tx_ack_o     (tx_ack_o),
      .tx_o         (tx_o),
      .busy_o       (busy_o),
      .fifo_full_o  (fifo_full_o),
      .fifo_empty_o (fifo_empty_o)
   );

   always #5 clk = ~clk;

   // Line capture, one sample per cycle away from the active edge.
   always @(negedge clk) begin
      if (cap_en) begin
         cap_tx.push_back(tx_o);
         cap_busy.push_back(busy_o);
      end
   end

   // Reference model: append the expected per-cycle line level of one frame.
   function automatic void add_frame(input logic [7:0] d, input int p, input bit pe,
                                     input bit po, input bit s2);
      int   pp;
      logic bits[$];
      pp = (p < 2) ? 2 : p;
      bits.push_back(1'b0);
      for (int i = 0; i < 8; i++) bits.push_back(d[i]);
      if (pe) bits.push_back((^d) ^ po);
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      foreach (bits[i]) for (int k = 0; k < pp; k++) exp_q.push_back(bits[i]);
   endfunction

   // Number of captured cycles that disagree with the model; wave begins 2 cycles after first accept.
   function automatic int wave_err();
      int e = 0;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (2 + i >= cap_tx.size()) e++;
         else if (cap_tx[2 + i] !== exp_q[i]) e++;
      end
      return e;
   endfunction

   function automatic int busy_ones();
      int c = 0;
      foreach (cap_busy[i]) if (cap_busy[i] === 1'b1) c++;
      return c;
   endfunction

   // Push burst_q back-to-back; capture starts right after the first accepting edge.
   task automatic send_burst();
      @(negedge clk);
      cap_en = 1'b0;
      for (int i = 0; i < burst_q.size(); i++) begin
         tx_req_i  = 1'b1;
         tx_data_i = burst_q[i];
         @(posedge clk);
         if (i == 0) begin
            #1;
            cap_tx.delete();
            cap_busy.delete();
            cap_en = 1'b1;
         end
         @(negedge clk);
      end
      tx_req_i = 1'b0;
   endtask

   task automatic finish_capture();
      repeat (exp_q.size() + 8) @(negedge clk);
      cap_en = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_cmp++; if (tx_o !== 1'b1)         begin n_err++; $display("FAIL reset_tx: got %b want 1", tx_o); end
      n_cmp++; if (busy_o !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      n_cmp++; if (fifo_full_o !== 1'b0)  begin n_err++; $display("FAIL reset_full: got %b want 0", fifo_full_o); end
      n_cmp++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", fifo_empty_o); end
      tx_req_i = 1'b1; #1;
      n_cmp++; if (tx_ack_o !== 1'b1)     begin n_err++; $display("FAIL reset_ack_hi: got %b want 1", tx_ack_o); end
      tx_req_i = 1'b0; #1;
      n_cmp++; if (tx_ack_o !== 1'b0)     begin n_err++; $display("FAIL reset_ack_lo: got %b want 0", tx_ack_o); end
      @(negedge clk);
      arst = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic();
      int e;
      bitperiod_i = 32'd4; parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
      exp_q.delete(); burst_q.delete();
      burst_q.push_back(8'h55);
      add_frame(8'h55, 4, 1'b0, 1'b0, 1'b0);
      send_burst();
      finish_capture();
      n_cmp++;
      if (cap_tx[0] !== 1'b1 || cap_tx[1] !== 1'b1 || cap_tx[2] !== 1'b0) begin
         n_err++; $display("FAIL basic_latency: got %b%b%b want 110", cap_tx[0], cap_tx[1], cap_tx[2]);
      end
      n_cmp++;
      if (cap_busy[0] !== 1'b0 || cap_busy[1] !== 1'b1) begin
         n_err++; $display("FAIL basic_busy_rise: got %b%b want 01", cap_busy[0], cap_busy[1]);
      end
      e = wave_err();
      n_cmp++; if (e !== 0) begin n_err++; $display("FAIL basic_wave: bad_cycles=%0d want 0", e); end
      n_cmp++; if (busy_ones() !== 40) begin n_err++; $display("FAIL basic_busy_len: got %0d want 40", busy_ones()); end
      n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", busy_o); end
   endtask

   task automatic test_parity();
      logic [7:0] d[3]  = '{8'h55, 8'h55, 8'h01};
      bit         po[3] = '{1'b0, 1'b1, 1'b0};
      bit         s2[3] = '{1'b0, 1'b0, 1'b1};
      int         e;
      for (int t = 0; t < 3; t++) begin
         bitperiod_i = 32'd4; parity_en_i = 1'b1; parity_odd_i = po[t]; stop2_i = s2[t];
         exp_q.delete(); burst_q.delete();
         burst_q.push_back(d[t]);
         add_frame(d[t], 4, 1'b1, po[t], s2[t]);
         send_burst();
         finish_capture();
         e = wave_err();
         n_cmp++; if (e !== 0) begin n_err++; $display("FAIL parity_wave[%0d]: bad_cycles=%0d want 0", t, e); end
         if (t == 2) begin
            n_cmp++; if (busy_ones() !== 48) begin n_err++; $display("FAIL parity_stop2_len: got %0d want 48", busy_ones()); end
            n_cmp++; if (cap_tx[2 + 36] !== 1'b1) begin n_err++; $display("FAIL parity_bit: got %b want 1", cap_tx[2 + 36]); end
         end
      end
      parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0;
   endtask

   task automatic test_full_fifo();
      int acks = 0;
      bit saw_full = 1'b0;
      int e;
      bitperiod_i = 32'd16;
      exp_q.delete();
      for (int i = 0; i < 9; i++) add_frame(8'(i), 16, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      for (int i = 0; i < 12; i++) begin
         tx_req_i = 1'b1; tx_data_i = 8'(i); #1;
         if (tx_ack_o === 1'b1) acks++;
         if (fifo_full_o === 1'b1) saw_full = 1'b1;
         @(posedge clk);
         if (i == 0) begin
            #1; cap_tx.delete(); cap_busy.delete(); cap_en = 1'b1;
         end
         @(negedge clk);
      end
      #1;
      n_cmp++; if (tx_ack_o !== 1'b0)    begin n_err++; $display("FAIL full_ack_low: got %b want 0", tx_ack_o); end
      n_cmp++; if (fifo_full_o !== 1'b1) begin n_err++; $display("FAIL full_flag: got %b want 1", fifo_full_o); end
      tx_req_i = 1'b0;
      n_cmp++; if (acks !== 9)           begin n_err++; $display("FAIL full_ack_count: got %0d want 9", acks); end
      n_cmp++; if (saw_full !== 1'b1)    begin n_err++; $display("FAIL full_seen: got %b want 1", saw_full); end
      finish_capture();
      e = wave_err();
      n_cmp++; if (e !== 0) begin n_err++; $display("FAIL full_wave: bad_cycles=%0d want 0", e); end
      n_cmp++; if (busy_ones() !== exp_q.size()) begin n_err++; $display("FAIL full_busy_len: got %0d want %0d", busy_ones(), exp_q.size()); end
      n_cmp++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL full_drained: got %b want 1", fifo_empty_o); end
   endtask

   task automatic test_cfg_change();
      int e;
      bitperiod_i = 32'd4;
      exp_q.delete(); burst_q.delete();
      burst_q.push_back(8'h3C); burst_q.push_back(8'hC3);
      add_frame(8'h3C, 4, 1'b0, 1'b0, 1'b0);
      add_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0);
      send_burst();
      repeat (10) @(negedge clk);
      bitperiod_i = 32'd8;
      finish_capture();
      e = wave_err();
      n_cmp++; if (e !== 0) begin n_err++; $display("FAIL cfg_change_wave: bad_cycles=%0d want 0", e); end
      bitperiod_i = 32'd4;
   endtask

   task automatic test_reset_mid();
      int zeros = 0;
      bitperiod_i = 32'd4;
      burst_q.delete();
      burst_q.push_back(8'hA5);
      for (int i = 0; i < 3; i++) burst_q.push_back(8'($urandom));
      send_burst();
      repeat (8) @(negedge clk);
      #1;
      n_cmp++; if (tx_o !== 1'b0) begin n_err++; $display("FAIL rstmid_pre: got %b want 0", tx_o); end
      #1 arst = 1'b1;
      #1;
      n_cmp++; if (tx_o !== 1'b1)         begin n_err++; $display("FAIL rstmid_tx: got %b want 1", tx_o); end
      n_cmp++; if (fifo_empty_o !== 1'b1) begin n_err++; $display("FAIL rstmid_empty: got %b want 1", fifo_empty_o); end
      n_cmp++; if (busy_o !== 1'b0)       begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy_o); end
      cap_en = 1'b0;
      @(negedge clk);
      arst = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (tx_o !== 1'b1 || busy_o !== 1'b0) zeros++;
      end
      n_cmp++; if (zeros !== 0) begin n_err++; $display("FAIL rstmid_quiet: active_cycles=%0d want 0", zeros); end
   endtask

   task automatic test_min_period();
      int e;
      bitperiod_i = 32'd0;
      exp_q.delete(); burst_q.delete();
      burst_q.push_back(8'hFF);
      add_frame(8'hFF, 0, 1'b0, 1'b0, 1'b0);
      send_burst();
      finish_capture();
      e = wave_err();
      n_cmp++; if (e !== 0) begin n_err++; $display("FAIL minper_wave: bad_cycles=%0d want 0", e); end
      n_cmp++; if (busy_ones() !== 20) begin n_err++; $display("FAIL minper_len: got %0d want 20", busy_ones()); end
      bitperiod_i = 32'd4;
   endtask

   task automatic test_random();
      int e, p, n;
      bit pe, po, s2;
      for (int it = 0; it < 5; it++) begin
         p  = $urandom_range(0, 7);
         pe = 1'($urandom_range(0, 1));
         po = 1'($urandom_range(0, 1));
         s2 = 1'($urandom_range(0, 1));
         n  = $urandom_range(1, 4);
         bitperiod_i = 32'(p); parity_en_i = pe; parity_odd_i = po; stop2_i = s2;
         exp_q.delete(); burst_q.delete();
         for (int k = 0; k < n; k++) begin
            burst_q.push_back(8'($urandom));
            add_frame(burst_q[k], p, pe, po, s2);
         end
         send_burst();
         finish_capture();
         e = wave_err();
         n_cmp++; if (e !== 0) begin n_err++; $display("FAIL rand_wave[%0d]: bad_cycles=%0d want 0 (p=%0d pe=%0d po=%0d s2=%0d n=%0d)", it, e, p, pe, po, s2, n); end
         n_cmp++; if (busy_ones() !== exp_q.size()) begin n_err++; $display("FAIL rand_busy_len[%0d]: got %0d want %0d", it, busy_ones(), exp_q.size()); end
      end
      parity_en_i = 1'b0; parity_odd_i = 1'b0; stop2_i = 1'b0; bitperiod_i = 32'd4;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity();
      test_full_fifo();
      test_cfg_change();
      test_reset_mid();
      test_min_period();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
